// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg: shared types and encodings for the EX->MEM stage.
//   state_t            RUN/KILL redirect shadow state
//   CTRL_*             bit positions inside the 8-bit ctrl bundle
//                      {regwrite,memread,memwrite,dmtype[2:0],wdsel[1:0]}
//   WDSEL_*            writeback source select codes
//   EXC_INSTR_MISALIGN trap cause, present only with MISALIGN_TRAP_EN
package ex_mem_stage_pkg;
    typedef enum logic {RUN, KILL} state_t;
    localparam int CTRL_REGWRITE  = 7;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_DMTYPE_LSB = 2;
    localparam int CTRL_WDSEL_LSB = 0;
    localparam logic [1:0] WDSEL_ALU = 2'd0;
    localparam logic [1:0] WDSEL_MEM = 2'd1;
    localparam logic [1:0] WDSEL_PC4 = 2'd2;
`ifdef MISALIGN_TRAP_EN
    localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
`endif
endpackage

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve: combinational branch/jump resolution.
//   in  pc, imm, alu_c, zero, br, jal, jalr
//   out taken (redirect wanted), target (redirect address), link (pc+4)
module ex_branch_resolve #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_c,
    input  logic            zero,
    input  logic            br,
    input  logic            jal,
    input  logic            jalr,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link
);
    assign taken  = (br & zero) | jal | jalr;
    assign target = jalr ? (alu_c & ~XLEN'(1)) : pc + imm;
    assign link   = pc + XLEN'(4);
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with branch resolution, fetch redirect and wrong-path kill.
//   clk, rstn (async active-low)
//   ex_*       : EX beat in (valid/ready handshake), pc, alu result, zero, store data, imm, rd, ctrl, class
//   flush      : synchronous kill of stage contents, highest priority
//   mem_*      : MEM beat out (valid/ready handshake), result, rs2, rd, ctrl
//   redirect_* : one-cycle fetch redirect pulse and target
//   MISALIGN_TRAP_EN adds mem_exc/mem_cause/mem_badaddr for misaligned taken targets.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int KILL_SLOTS = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_alu_c,
    input  logic            ex_zero,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [4:0]      ex_rd,
    input  logic [7:0]      ex_ctrl,
    input  logic            ex_br,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic            flush,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_rs2,
    output logic [4:0]      mem_rd,
    output logic [7:0]      mem_ctrl,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            mem_exc,
    output logic [3:0]      mem_cause,
    output logic [XLEN-1:0] mem_badaddr
`endif
);
    localparam logic [1:0] KS = 2'(KILL_SLOTS);
    logic            taken, acc, load, drop, redir;
    logic [XLEN-1:0] target, link;
    logic [7:0]      ctrl_in;
    logic [1:0]      kcnt, kcnt_nxt;
    state_t          state, state_nxt;

    ex_branch_resolve #(.XLEN(XLEN)) u_resolve (
        .pc(ex_pc), .imm(ex_imm), .alu_c(ex_alu_c), .zero(ex_zero),
        .br(ex_br), .jal(ex_jal), .jalr(ex_jalr),
        .taken(taken), .target(target), .link(link)
    );

    assign ex_ready = ~mem_valid | mem_ready;
    assign acc      = ex_valid & ex_ready;
    assign load     = acc & (state == RUN);
    // Beats accepted in KILL are wrong-path: consumed but never reach MEM.
    assign drop     = acc & (state == KILL);

`ifdef MISALIGN_TRAP_EN
    logic mis;
    assign mis     = taken & (target[1:0] != 2'b00);
    assign redir   = taken & ~mis;
    assign ctrl_in = mis ? (ex_ctrl & ~(8'b1 << CTRL_REGWRITE)) : ex_ctrl;
`else
    assign redir   = taken;
    assign ctrl_in = ex_ctrl;
`endif

    always_comb begin
        state_nxt = state;
        kcnt_nxt  = kcnt;
        if (flush) begin
            state_nxt = RUN;
            kcnt_nxt  = '0;
        end else if (load & redir) begin
            state_nxt = KILL;
            kcnt_nxt  = KS;
        end else if (drop) begin
            state_nxt = (kcnt == 2'd1) ? RUN : KILL;
            kcnt_nxt  = kcnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= RUN;
            kcnt           <= '0;
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_rs2        <= '0;
            mem_rd         <= '0;
            mem_ctrl       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
`ifdef MISALIGN_TRAP_EN
            mem_exc        <= 1'b0;
            mem_cause      <= '0;
            mem_badaddr    <= '0;
`endif
        end else begin
            state          <= state_nxt;
            kcnt           <= kcnt_nxt;
            mem_valid      <= ~flush & (load | (mem_valid & ~mem_ready));
            // Single pulse: the redirecting beat moves us to KILL, so no reload can re-fire it.
            redirect_valid <= ~flush & load & redir;
            if (load & ~flush) begin
                mem_result <= (ex_jal | ex_jalr) ? link : ex_alu_c;
                mem_rs2    <= ex_rs2;
                mem_rd     <= ex_rd;
                mem_ctrl   <= ctrl_in;
`ifdef MISALIGN_TRAP_EN
                mem_exc     <= mis;
                mem_cause   <= EXC_INSTR_MISALIGN;
                mem_badaddr <= mis ? target : '0;
`endif
            end
            if (load & redir & ~flush)
                redirect_pc <= target;
        end
    end
endmodule
